// File: rtl/lzss_dec_expand_pkg.sv
// Shared definitions for the LZSS expand stage.
// Provides default widths, the derived history depth and the FSM state encoding.
`timescale 1ns/1ps
package lzss_pkg;
  localparam int DATA_W     = 8;
  localparam int OFFSET_W   = 6;
  localparam int LENGTH_W   = 3;
  localparam int HIST_DEPTH = 1 << OFFSET_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_COPY = 1'b1
  } state_t;
endpackage

// File: rtl/lzss_dec_expand_if.sv
// Token-in / byte-out bundle of the LZSS expand stage.
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; the producer holds its payload stable while valid & ~ready.
//   token side : i_valid, ow_ready, i_last, i_flag, i_data_or_offset, i_length
//   byte side  : o_valid, i_ready, o_last, o_data
// slave  = the expand stage, master = its environment (token source / byte sink).
`timescale 1ns/1ps
interface lzss_dec_expand_if #(
  parameter int pDataWidth   = lzss_pkg::DATA_W,
  parameter int pLengthWidth = lzss_pkg::LENGTH_W
);
  logic                    i_valid;
  logic                    ow_ready;
  logic                    i_last;
  logic                    i_flag;
  logic [pDataWidth-1:0]   i_data_or_offset;
  logic [pLengthWidth-1:0] i_length;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_last;
  logic [pDataWidth-1:0]   o_data;

  modport slave (
    input  i_valid, i_last, i_flag, i_data_or_offset, i_length, i_ready,
    output ow_ready, o_valid, o_last, o_data
  );

  modport master (
    output i_valid, i_last, i_flag, i_data_or_offset, i_length, i_ready,
    input  ow_ready, o_valid, o_last, o_data
  );
endinterface

// File: rtl/lzss_dec_expand_history.sv
// Sliding-window history for the LZSS expand stage.
// 2^pOffsetWidth x pDataWidth register file, cleared on reset.
//   clk, rst_x : clock, asynchronous active-low reset
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : asynchronous read port (sees a write from the previous edge)
`timescale 1ns/1ps
module lzss_dec_history #(
  parameter int pDataWidth   = lzss_pkg::DATA_W,
  parameter int pOffsetWidth = lzss_pkg::OFFSET_W
) (
  input  logic                    clk,
  input  logic                    rst_x,
  input  logic                    we,
  input  logic [pOffsetWidth-1:0] waddr,
  input  logic [pDataWidth-1:0]   wdata,
  input  logic [pOffsetWidth-1:0] raddr,
  output logic [pDataWidth-1:0]   rdata
);
  localparam int DEPTH = 1 << pOffsetWidth;

  logic [pDataWidth-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/lzss_dec_expand.sv
// LZSS expand stage: turns literal/match tokens into a byte stream, one byte
// per cycle, keeping a 2^pOffsetWidth-byte history for match copies.
//   clk, rst_x : clock, asynchronous active-low reset
//   io         : token input and byte output (lzss_dec_expand_if.slave)
//   dbg_state  : current FSM state
`timescale 1ns/1ps
module lzss_dec_expand
  import lzss_pkg::*;
#(
  parameter int pDataWidth   = DATA_W,
  parameter int pOffsetWidth = OFFSET_W,
  parameter int pLengthWidth = LENGTH_W
) (
  input  logic                clk,
  input  logic                rst_x,
  lzss_dec_expand_if.slave    io,
  output state_t              dbg_state
);
  localparam logic [pOffsetWidth-1:0] OFF_ONE = 1;
  localparam logic [pLengthWidth-1:0] LEN_ONE = 1;

  state_t                  state, state_nx;
  logic [pOffsetWidth-1:0] wp, src, match_src, rd_addr;
  logic [pLengthWidth-1:0] rem, len_eff, rem_init;
  logic                    last_pend;
  logic [pDataWidth-1:0]   rd_data, load_data, data_q;
  logic                    valid_q, last_q;
  logic                    out_ack, slot_free, in_ack, ready;
  logic                    load, load_last;

  assign out_ack   = valid_q & io.i_ready;
  assign slot_free = ~valid_q | out_ack;
  // No new token while a final byte is waiting: the stream end resets wp.
  assign ready     = (state == ST_IDLE) & slot_free & ~last_q;
  assign in_ack    = io.i_valid & ready;

  // Offset d points d+1 bytes back from the next write position.
  assign match_src = wp - io.i_data_or_offset[pOffsetWidth-1:0] - OFF_ONE;
  assign len_eff   = (io.i_length == '0) ? LEN_ONE : io.i_length;
  assign rem_init  = len_eff - LEN_ONE;
  assign rd_addr   = (state == ST_COPY) ? src : match_src;

  lzss_dec_history #(
    .pDataWidth  (pDataWidth),
    .pOffsetWidth(pOffsetWidth)
  ) u_hist (
    .clk  (clk),
    .rst_x(rst_x),
    .we   (load),
    .waddr(wp),
    .wdata(load_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    load_data = rd_data;
    load_last = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_ack) begin
          load = 1'b1;
          if (io.i_flag) begin
            load_data = rd_data;
            load_last = io.i_last & (rem_init == '0);
            if (rem_init != '0) state_nx = ST_COPY;
          end else begin
            load_data = io.i_data_or_offset;
            load_last = io.i_last;
          end
        end
      end
      ST_COPY: begin
        if (slot_free) begin
          load      = 1'b1;
          load_last = last_pend & (rem == LEN_ONE);
          if (rem == LEN_ONE) state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state     <= ST_IDLE;
      wp        <= '0;
      src       <= '0;
      rem       <= '0;
      last_pend <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        data_q  <= load_data;
        valid_q <= 1'b1;
        last_q  <= load_last;
        wp      <= wp + OFF_ONE;
      end else if (out_ack) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        // Each stream restarts the window position; contents stay.
        if (last_q) wp <= '0;
      end
      if (in_ack && io.i_flag) begin
        src       <= match_src + OFF_ONE;
        rem       <= rem_init;
        last_pend <= io.i_last;
      end else if (state == ST_COPY && slot_free) begin
        src <= src + OFF_ONE;
        rem <= rem - LEN_ONE;
      end
    end
  end

  assign io.ow_ready = ready;
  assign io.o_valid  = valid_q;
  assign io.o_last   = last_q;
  assign io.o_data   = data_q;
  assign dbg_state   = state;
endmodule

// File: tb/tb_lzss_dec_expand.sv
// Directed self-checking bench for lzss_dec_expand.
`timescale 1ns/1ps
module tb_lzss_dec_expand;
  import lzss_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_x = 1'b0;
  always #5 clk = ~clk;

  lzss_dec_expand_if io ();
  state_t dbg_state;

  lzss_dec_expand dut (
    .clk      (clk),
    .rst_x    (rst_x),
    .io       (io.slave),
    .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_x && io.o_valid && io.i_ready) begin
      got_q.push_back(io.o_data);
      got_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present one token and hold it until accepted
  task automatic send_tok(input logic flag, input logic [7:0] val,
                          input logic [2:0] len, input logic last);
    int n;
    io.i_valid          = 1'b1;
    io.i_flag           = flag;
    io.i_data_or_offset = val;
    io.i_length         = len;
    io.i_last           = last;
    n = 0;
    while (!io.ow_ready && n < 20) begin
      step();
      n++;
    end
    check("tok_ready", {31'd0, io.ow_ready}, 32'd1);
    step();
    io.i_valid = 1'b0;
    io.i_last  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((io.o_valid || dbg_state == ST_COPY) && n < 50) begin
      step();
      n++;
    end
    check({tag, "_drain"}, {31'd0, io.o_valid}, 32'd0);
  endtask

  task automatic check_stream(input string tag, input bit consec);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    if (consec)
      for (int i = 1; i < got_cyc_q.size(); i++)
        check($sformatf("%s_gap%0d", tag, i), got_cyc_q[i] - got_cyc_q[i-1], 32'd1);
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
  endtask

  initial begin
    io.i_valid          = 1'b0;
    io.i_flag           = 1'b0;
    io.i_data_or_offset = '0;
    io.i_length         = '0;
    io.i_last           = 1'b0;
    io.i_ready          = 1'b1;

    // reset state
    #1;
    check("rst_o_valid", {31'd0, io.o_valid}, 32'd0);
    check("rst_o_last", {31'd0, io.o_last}, 32'd0);
    check("rst_o_data", {24'd0, io.o_data}, 32'd0);
    check("rst_ow_ready", {31'd0, io.ow_ready}, 32'd1);
    check("rst_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
    step();
    step();
    rst_x = 1'b1;
    step();

    // literals then a match of the same three bytes
    send_tok(1'b0, 8'h41, 3'd0, 1'b0);
    check("lit_latency", {24'd0, io.o_data}, 32'h41);
    send_tok(1'b0, 8'h42, 3'd0, 1'b0);
    send_tok(1'b0, 8'h43, 3'd0, 1'b0);
    send_tok(1'b1, 8'd2, 3'd3, 1'b0);
    check("match_latency", {24'd0, io.o_data}, 32'h41);
    wait_drain("t1");
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h41, 8'h42, 8'h43};
    check_stream("t1", 1'b1);

    // overlapping match replicates one byte; ow_ready low during COPY
    send_tok(1'b0, 8'h55, 3'd0, 1'b0);
    send_tok(1'b1, 8'd0, 3'd4, 1'b0);
    check("copy_ready0", {31'd0, io.ow_ready}, 32'd0);
    step();
    check("copy_ready1", {31'd0, io.ow_ready}, 32'd0);
    step();
    check("copy_ready2", {31'd0, io.ow_ready}, 32'd0);
    step();
    check("copy_ready_back", {31'd0, io.ow_ready}, 32'd1);
    wait_drain("t2");
    exp_q = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
    check_stream("t2", 1'b1);

    // backpressure during a match (wp=11, offset 10 -> src 0)
    send_tok(1'b1, 8'd10, 3'd4, 1'b0);
    check("bp_first", {24'd0, io.o_data}, 32'h41);
    step();
    io.i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp_hold_valid%0d", k), {31'd0, io.o_valid}, 32'd1);
      check($sformatf("bp_hold_data%0d", k), {24'd0, io.o_data}, 32'h42);
    end
    io.i_ready = 1'b1;
    wait_drain("t3");
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h41};
    check_stream("t3", 1'b0);

    // last byte, stream restart, read of a never-written entry
    send_tok(1'b0, 8'h7E, 3'd0, 1'b1);
    check("last_data", {24'd0, io.o_data}, 32'h7E);
    check("last_flag", {31'd0, io.o_last}, 32'd1);
    check("last_ready", {31'd0, io.ow_ready}, 32'd0);
    io.i_ready = 1'b0;
    step();
    check("last_hold_flag", {31'd0, io.o_last}, 32'd1);
    check("last_hold_ready", {31'd0, io.ow_ready}, 32'd0);
    io.i_ready = 1'b1;
    step();
    check("after_last_valid", {31'd0, io.o_valid}, 32'd0);
    check("after_last_flag", {31'd0, io.o_last}, 32'd0);
    check("after_last_ready", {31'd0, io.ow_ready}, 32'd1);
    send_tok(1'b1, 8'd0, 3'd1, 1'b1);
    check("wrap_unwritten", {24'd0, io.o_data}, 32'h00);
    check("wrap_last", {31'd0, io.o_last}, 32'd1);
    step();
    check("wrap_done_valid", {31'd0, io.o_valid}, 32'd0);
    exp_q = '{8'h7E, 8'h00};
    check_stream("t4", 1'b0);

    // 70 literals then offset 63 across the window wrap
    for (int k = 0; k < 70; k++) begin
      send_tok(1'b0, 8'(k), 3'd0, 1'b0);
      exp_q.push_back(8'(k));
    end
    send_tok(1'b1, 8'd63, 3'd2, 1'b0);
    exp_q.push_back(8'h06);
    exp_q.push_back(8'h07);
    wait_drain("t5");
    check_stream("t5", 1'b1);

    // reset mid-COPY (wp=8, offset 0 -> repeats 0x07)
    send_tok(1'b1, 8'd0, 3'd4, 1'b0);
    check("rst_copy_first", {24'd0, io.o_data}, 32'h07);
    step();
    check("rst_copy_state", {31'd0, dbg_state}, {31'd0, ST_COPY});
    rst_x = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, io.o_valid}, 32'd0);
    check("mid_rst_last", {31'd0, io.o_last}, 32'd0);
    check("mid_rst_data", {24'd0, io.o_data}, 32'd0);
    check("mid_rst_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
    step();
    rst_x = 1'b1;
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
    check("post_rst_ready", {31'd0, io.ow_ready}, 32'd1);
    send_tok(1'b0, 8'h11, 3'd0, 1'b0);
    check("post_rst_valid", {31'd0, io.o_valid}, 32'd1);
    check("post_rst_data", {24'd0, io.o_data}, 32'h11);
    // offset 1 from wp=1 reads entry 63, cleared by the reset
    send_tok(1'b1, 8'd1, 3'd1, 1'b0);
    check("post_rst_hist", {24'd0, io.o_data}, 32'h00);
    wait_drain("t6");
    exp_q = '{8'h11, 8'h00};
    check_stream("t6", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
